// File: rtl/universal_shift_reg_ctrl.sv
// Universal shift register with a counted burst controller.
// Modes: hold, shift left/right, rotate left/right, parallel load, clear.
// A START with a shift/rotate MODE and a non-zero COUNT runs exactly COUNT
// steps of the captured mode, then pulses DONE for one cycle.
module universal_shift_reg_ctrl #(
   parameter int REG_SIZE = 4,
   parameter int CNT_W    = 8
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic [2:0]          MODE,
   input  logic                START,
   input  logic [CNT_W-1:0]    COUNT,
   input  logic                SER_IN_L,
   input  logic                SER_IN_R,
   input  logic [REG_SIZE-1:0] PAR_IN,
   output logic [REG_SIZE-1:0] Q,
   output logic                SER_OUT_L,
   output logic                SER_OUT_R,
   output logic                BUSY,
   output logic                DONE
);

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_SHL   = 3'b001,
      OP_SHR   = 3'b010,
      OP_ROL   = 3'b011,
      OP_ROR   = 3'b100,
      OP_LOAD  = 3'b101,
      OP_CLEAR = 3'b110,
      OP_RSVD  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e              state_r,  state_nxt;
   op_e                 op_r,     op_nxt;
   logic [CNT_W-1:0]    cnt_r,    cnt_nxt;
   logic [REG_SIZE-1:0] q_r,      q_nxt;
   logic                busy_r,   busy_nxt;
   logic                done_r,   done_nxt;

   // Only the four shift/rotate codes may be repeated by a burst.
   function automatic logic is_step_op(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
   endfunction

   // Next register value for one application of an operation.
   function automatic logic [REG_SIZE-1:0] apply_op(
      input logic [2:0]          op,
      input logic [REG_SIZE-1:0] q,
      input logic                sl,
      input logic                sr,
      input logic [REG_SIZE-1:0] par
   );
      logic [REG_SIZE-1:0] r;
      r = q;
      case (op)
         OP_SHL:   r = {q[REG_SIZE-2:0], sl};
         OP_SHR:   r = {sr, q[REG_SIZE-1:1]};
         OP_ROL:   r = {q[REG_SIZE-2:0], q[REG_SIZE-1]};
         OP_ROR:   r = {q[0], q[REG_SIZE-1:1]};
         OP_LOAD:  r = par;
         OP_CLEAR: r = '0;
         default:  r = q;   // hold and the reserved code
      endcase
      return r;
   endfunction

   // Next-state, datapath and registered-output decode for the burst FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_nxt = state_r;
      op_nxt    = op_r;
      cnt_nxt   = cnt_r;
      q_nxt     = q_r;

      case (state_r)
         S_IDLE: begin
            if (START && is_step_op(MODE)) begin
               // Capture the burst; the register itself is untouched this edge.
               op_nxt    = op_e'(MODE);
               cnt_nxt   = COUNT;
               state_nxt = (COUNT != '0) ? S_RUN : S_FIN;
            end else begin
               q_nxt = apply_op(MODE, q_r, SER_IN_L, SER_IN_R, PAR_IN);
            end
         end
         S_RUN: begin
            q_nxt   = apply_op(op_r, q_r, SER_IN_L, SER_IN_R, PAR_IN);
            cnt_nxt = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt == S_RUN);
      done_nxt = (state_nxt == S_FIN);
   end

   // State, data and status registers with synchronous reset.
   always_ff @(posedge CLOCK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (RESET) begin
         state_r <= S_IDLE;
         op_r    <= OP_HOLD;
         cnt_r   <= '0;
         q_r     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         op_r    <= op_nxt;
         cnt_r   <= cnt_nxt;
         q_r     <= q_nxt;
         busy_r  <= busy_nxt;
         done_r  <= done_nxt;
      end
   end

   assign Q         = q_r;
   assign BUSY      = busy_r;
   assign DONE      = done_r;
   assign SER_OUT_L = q_r[REG_SIZE-1];
   assign SER_OUT_R = q_r[0];

endmodule
